// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and defaults for the pipeline hazard controller
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    FLUSH     = 2'd1,
    IMEM_WAIT = 2'd2
  } state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam int FLUSH_CYCLES_DEF = 1;
  localparam int TIMEOUT_DEF      = 255;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with enable and async active-low clear
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         en,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - stall/flush control for a 5-stage pipeline with load-use,
// taken-branch and instruction-memory wait handling plus a sticky fetch watchdog.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF,
  parameter int TIMEOUT      = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        idex_memread,
  input  logic [4:0]  idex_rt,
  input  logic        ex_branch_taken,
  input  logic        imem_ready,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        imem_timeout,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  localparam int            WW        = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] TMO       = WW'(TIMEOUT);
  localparam logic [1:0]    FCNT_INIT = 2'(FLUSH_CYCLES - 1);

  state_e        state_q, state_d;
  logic [1:0]    fcnt_q, fcnt_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          tmo_q, tmo_d;
  logic          lu;
  logic          branch_ev;

  assign lu = idex_memread && (idex_rt != REG_ZERO) &&
              ((idex_rt == id_rs) || (idex_rt == id_rt));

  always_comb begin
    state_d     = state_q;
    fcnt_d      = fcnt_q;
    wait_d      = '0;
    tmo_d       = tmo_q;
    branch_ev   = 1'b0;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;

    if (ex_branch_taken) begin
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      branch_ev   = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        state_d = FLUSH;
        fcnt_d  = FCNT_INIT;
      end else begin
        state_d = RUN;
        fcnt_d  = '0;
      end
    end else if (state_q == FLUSH) begin
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      fcnt_d      = fcnt_q - 1'b1;
      if (fcnt_q <= 2'd1) begin
        state_d = RUN;
        fcnt_d  = '0;
      end
    end else if (!imem_ready) begin
      // the entering RUN cycle counts as the first wait cycle
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
      state_d     = IMEM_WAIT;
      wait_d      = (wait_q == TMO) ? wait_q : wait_q + 1'b1;
      if (wait_d == TMO) tmo_d = 1'b1;
    end else begin
      state_d = RUN;
      if (lu) begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
      end
    end

    if (!reset) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      fcnt_q  <= '0;
      wait_q  <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      wait_q  <= wait_d;
      tmo_q   <= tmo_d;
    end
  end

  assign imem_timeout = tmo_q;

  sat_counter #(.W(16)) u_stall_cnt (
    .clk   (clk),
    .clr_n (reset),
    .en    (!pc_write),
    .cnt   (stall_cnt)
  );

  sat_counter #(.W(16)) u_flush_cnt (
    .clk   (clk),
    .clr_n (reset),
    .en    (branch_ev),
    .cnt   (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

  // output vector order: {pc_write, ifid_write, ifid_flush, idex_bubble}
  localparam logic [3:0] NORM  = 4'b1100;
  localparam logic [3:0] STALL = 4'b0001;
  localparam logic [3:0] FLSH  = 4'b1011;
  localparam logic [3:0] ZERO  = 4'b0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  id_rs, id_rt, idex_rt;
  logic        idex_memread, ex_branch_taken, imem_ready;
  logic        pc_write, ifid_write, ifid_flush, idex_bubble, imem_timeout;
  logic [15:0] stall_cnt, flush_cnt;
  logic [3:0]  outs;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  assign outs = {pc_write, ifid_write, ifid_flush, idex_bubble};

  hazard_ctrl #(.FLUSH_CYCLES(3), .TIMEOUT(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .idex_memread    (idex_memread),
    .idex_rt         (idex_rt),
    .ex_branch_taken (ex_branch_taken),
    .imem_ready      (imem_ready),
    .pc_write        (pc_write),
    .ifid_write      (ifid_write),
    .ifid_flush      (ifid_flush),
    .idex_bubble     (idex_bubble),
    .imem_timeout    (imem_timeout),
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt)
  );

  task automatic idle;
    idex_memread = 1'b0; idex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
    ex_branch_taken = 1'b0; imem_ready = 1'b1;
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic chk_outs(input string name, input logic [3:0] exp);
    #1;
    vectors++;
    if (outs !== exp) begin
      errors++;
      $display("FAIL %s: outs=%b expected=%b", name, outs, exp);
    end
  endtask

  task automatic chk_cnt(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic pulse_reset;
    reset = 1'b0;
    #1;
    vectors++;
    if ({outs, imem_timeout, stall_cnt, flush_cnt} !== 37'd0) begin
      errors++;
      $display("FAIL reset_pulse: outs=%b tmo=%b stall=%h flush=%h expected all 0",
               outs, imem_timeout, stall_cnt, flush_cnt);
    end
    #1 reset = 1'b1;
  endtask

  task automatic test_reset;
    idle();
    reset = 1'b0;
    imem_ready = 1'b0;
    tick(); tick();
    chk_outs("reset_outs", ZERO);
    chk_cnt("reset_stall_cnt", stall_cnt, 16'd0);
    chk_cnt("reset_flush_cnt", flush_cnt, 16'd0);
    chk_cnt("reset_timeout", {15'd0, imem_timeout}, 16'd0);
    tick();
    idle();
    reset = 1'b1;
    chk_outs("after_reset_normal", NORM);
    tick();
  endtask

  task automatic test_load_use;
    idex_memread = 1'b1; idex_rt = 5'd8; id_rs = 5'd8;
    chk_outs("lu_rs_stall", STALL);
    tick();
    idle();
    chk_outs("lu_one_cycle", NORM);
    chk_cnt("lu_stall_cnt", stall_cnt, 16'd1);
    tick();
    idex_memread = 1'b1; idex_rt = 5'd9; id_rt = 5'd9; id_rs = 5'd3;
    chk_outs("lu_rt_stall", STALL);
    tick();
    idex_memread = 1'b0;
    chk_outs("no_load_no_stall", NORM);
    chk_cnt("lu_stall_cnt2", stall_cnt, 16'd2);
    tick();
  endtask

  task automatic test_reg_zero;
    idex_memread = 1'b1; idex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
    chk_outs("reg_zero_no_stall", NORM);
    tick();
    chk_cnt("reg_zero_stall_cnt", stall_cnt, 16'd2);
    idle();
  endtask

  task automatic test_flush;
    ex_branch_taken = 1'b1;
    chk_outs("flush_c1", FLSH);
    tick();
    ex_branch_taken = 1'b0;
    chk_outs("flush_c2", FLSH);
    tick();
    chk_outs("flush_c3", FLSH);
    tick();
    chk_outs("flush_done", NORM);
    chk_cnt("flush_cnt1", flush_cnt, 16'd1);
    tick();
  endtask

  task automatic test_simultaneous;
    ex_branch_taken = 1'b1; imem_ready = 1'b0;
    idex_memread = 1'b1; idex_rt = 5'd8; id_rs = 5'd8;
    chk_outs("simul_branch_wins", FLSH);
    tick();
    idle();
    chk_outs("simul_flush_c2", FLSH);
    tick();
    chk_outs("simul_flush_c3", FLSH);
    tick();
    chk_outs("simul_run", NORM);
    chk_cnt("simul_flush_cnt", flush_cnt, 16'd2);
    chk_cnt("simul_stall_cnt", stall_cnt, 16'd2);
    tick();
  endtask

  task automatic test_watchdog;
    imem_ready = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      chk_outs("wait_outs", STALL);
      chk_cnt("wait_timeout", {15'd0, imem_timeout}, (k >= 5) ? 16'd1 : 16'd0);
      tick();
    end
    imem_ready = 1'b1;
    chk_outs("wait_exit", NORM);
    chk_cnt("wait_stall_cnt", stall_cnt, 16'd8);
    tick();
    imem_ready = 1'b0;
    tick();
    imem_ready = 1'b1; idex_memread = 1'b1; idex_rt = 5'd4; id_rs = 5'd4;
    chk_outs("wait_exit_lu", STALL);
    tick();
    idle();
    chk_cnt("wait_lu_stall_cnt", stall_cnt, 16'd10);
    chk_cnt("timeout_sticky", {15'd0, imem_timeout}, 16'd1);
    imem_ready = 1'b0;
    tick();
    pulse_reset();
    imem_ready = 1'b1;
    chk_outs("reset_mid_wait_run", NORM);
    tick();
    ex_branch_taken = 1'b1;
    tick();
    ex_branch_taken = 1'b0;
    pulse_reset();
    chk_outs("reset_mid_flush_run", NORM);
    tick();
  endtask

  task automatic test_saturation;
    pulse_reset();
    idex_memread = 1'b1; idex_rt = 5'd7; id_rs = 5'd7;
    repeat (65534) tick();
    chk_cnt("sat_fffe", stall_cnt, 16'hFFFE);
    repeat (70000 - 65534) tick();
    chk_cnt("sat_ffff", stall_cnt, 16'hFFFF);
    chk_outs("sat_still_stall", STALL);
    idle();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_reg_zero();
    test_flush();
    test_simultaneous();
    test_watchdog();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
